imem_dmem_port_arbiter: RTL and testbench
=========================================

Name: imem_dmem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM).
- Arbitrates between the two requesters and sequences each access through a fixed-latency wait-state FSM.
- Returns read data to the winner with a one-cycle ready pulse.
- The fetch and memory stages hold (stall) until their ready pulse arrives. The hazard unit ORs `~if_ready`/`~dm_ready` into its stall/flush logic.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- LAT, 2, memory access cycles per transaction (>=1)
- MAX_DM_BURST, 4, consecutive DM grants allowed while IF is pending before IF is forced

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address (PCF)
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address (ALUResultM)
- dm_wdata  in  DATA_W  store data (WriteDataM)
- dm_rdata  out  DATA_W  load data
- dm_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle

Behaviour:
- Reset is clk/rst as named; asynchronous, active-high.
- On reset:
  - state = IDLE
  - all outputs 0
  - if_rdata and dm_rdata = 0
  - dm_streak = 0
  - wait counter = 0
- Reset mid-access abandons the transaction immediately: mem_en and mem_we drop asynchronously, and no ready pulse is issued.
- FSM states are IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If neither request is active, stay in IDLE.
  - Otherwise, latch grant, address, we and wdata, load counter = LAT-1, and go to ACCESS.
- Arbitration (IDLE only):
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both: grant DM unless dm_streak == MAX_DM_BURST, in which case grant IF.
  - DM priority is required because MEM holds the older instruction.
- dm_streak rules:
  - Increments on a DM grant while if_req = 1, saturating at MAX_DM_BURST.
  - Clears on any IF grant, or on a DM grant while if_req = 0.
- ACCESS:
  - mem_en = 1; mem_addr, mem_we and mem_wdata are held constant for all LAT cycles.
  - mem_we = 1 only for DM store grants.
  - The counter decrements each cycle.
  - When the counter == 0, capture mem_rdata into the winner's rdata register (loads and fetches only) and go to DONE.
- DONE:
  - mem_en = 0.
  - Pulse the winner's ready for exactly one cycle.
  - The rdata output is valid this cycle and held until that requester's next completion.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle t, mem_en high during t+1..t+LAT, ready at t+LAT+1. Next arbitration happens at t+LAT+2.
- Stores leave dm_rdata unchanged.
- A request that arrives mid-transaction waits; its inputs are sampled only in IDLE.
- A request dropped before ready does not abort the access: the access completes and the ready pulse still fires. Requesters must not drop a request early.
- Never are if_ready and dm_ready both high. Never are both requesters driven to memory in the same cycle.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - grant encoding GNT_IF = 1'b0, GNT_DM = 1'b1
  - default LAT / MAX_DM_BURST constants
- One sub-module, mem_wait_counter: loadable down-counter with load value LAT-1 and a zero flag, plus async reset.

Test Plan:
- Only if_req, if_addr = 0x10, LAT = 2, mem_rdata = 0x00500093 → mem_en high cycles 1–2 with mem_addr = 0x10; if_ready pulses cycle 3 with if_rdata = 0x00500093.
- Only dm_req store, dm_addr = 0x40, dm_wdata = 0xDEADBEEF → mem_we = 1 for 2 cycles with wdata held; dm_ready pulses cycle 3; dm_rdata unchanged.
- if_req and dm_req (load) asserted together → DM served first (dm_ready at cycle 3); IF granted in the next IDLE (if_ready at cycle 7).
- dm_req held continuously for 6 transactions with if_req held → DM granted 4 times, then IF, then DM; dm_streak observed 1, 2, 3, 4, 0.
- rst asserted during ACCESS cycle 1 of a store → mem_en and mem_we go 0 in the same cycle with no clock edge; no ready pulse; state IDLE after reset release.
- LAT = 1 build, back-to-back IF requests → if_ready every 3 cycles; if_rdata updated each time.

Source files
------------

// File: rtl/imem_dmem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : arb_pkg                                                 |
// | Purpose  : Shared types and constants for the unified IF/MEM port  |
// |            arbiter: FSM state encoding, grant encoding and the     |
// |            default latency / DM-burst limits.                      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Which requester owns the current transaction
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int c_default_lat           = 2;
  localparam int c_default_max_dm_burst  = 4;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter_wait_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mem_wait_counter                                        |
// | Purpose  : Loadable down-counter that times the memory wait states |
// |            of one transaction. Loads LAT-1, counts down to zero    |
// |            and stops there.                                        |
// | Ports    : clk, rst (async, active-high)                           |
// |            load  - reload with LAT-1 (has priority over dec)       |
// |            dec   - decrement by one when not already zero          |
// |            zero  - counter value is zero                           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module mem_wait_counter
  import arb_pkg::*;
#(
  parameter int LAT = c_default_lat
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // LAT = 1 still needs a one-bit register to stay well-formed
  localparam int                 c_cnt_w    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(LAT - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule : mem_wait_counter
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : imem_dmem_port_arbiter                                  |
// | Purpose  : Shares one single-ported unified memory between the     |
// |            fetch stage (IF) and the memory stage (DM). Each access |
// |            runs IDLE -> ACCESS (LAT cycles) -> DONE, and the       |
// |            winner gets a one-cycle ready pulse with its read data. |
// | Ports    : clk, rst            - clock, async active-high reset    |
// |            if_req/if_addr      - fetch request (held until ready)  |
// |            if_rdata/if_ready   - fetched word / completion pulse   |
// |            dm_req/we/addr/wdata- load/store request (held)         |
// |            dm_rdata/dm_ready   - load data / completion pulse      |
// |            mem_en/we/addr/wdata- memory command, all registered    |
// |            mem_rdata           - memory data, valid last ACCESS    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module imem_dmem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LAT          = c_default_lat,
  parameter int MAX_DM_BURST = c_default_max_dm_burst
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                    c_streak_w   = $clog2(MAX_DM_BURST + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DM_BURST);

  state_t              r_state;
  logic                r_grant;
  logic [c_streak_w-1:0] r_dm_streak;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_ready;
  logic                r_dm_ready;

  logic w_any_req;
  logic w_grant;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;

  // DM wins by default (MEM holds the older instruction); IF is forced
  // only once DM has taken MAX_DM_BURST grants in a row while IF waited.
  always_comb begin
    w_any_req = if_req | dm_req;
    w_grant   = GNT_IF;
    if (dm_req && !(if_req && (r_dm_streak == c_streak_max))) begin
      w_grant = GNT_DM;
    end
  end

  assign w_cnt_load = (r_state == IDLE) && w_any_req;
  assign w_cnt_dec  = (r_state == ACCESS);

  mem_wait_counter #(
    .LAT (LAT)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (w_cnt_load),
    .dec  (w_cnt_dec),
    .zero (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= GNT_IF;
      r_dm_streak <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_grant;
            r_mem_en <= 1'b1;
            if (w_grant == GNT_DM) begin
              r_mem_we    <= dm_we;
              r_mem_addr  <= dm_addr;
              r_mem_wdata <= dm_wdata;
              // Streak only grows while IF is actually being held off
              if (if_req) begin
                r_dm_streak <= (r_dm_streak == c_streak_max) ? c_streak_max
                                                             : r_dm_streak + 1'b1;
              end else begin
                r_dm_streak <= '0;
              end
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_dm_streak <= '0;
            end
            r_state <= ACCESS;
          end
        end

        ACCESS: begin
          if (w_cnt_zero) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_grant == GNT_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_ready <= 1'b1;
            end else begin
              // Stores leave the last load result visible
              if (!r_mem_we) begin
                r_dm_rdata <= mem_rdata;
              end
              r_dm_ready <= 1'b1;
            end
            r_state <= DONE;
          end
        end

        DONE: begin
          r_if_ready <= 1'b0;
          r_dm_ready <= 1'b0;
          r_state    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ready  = r_dm_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule : imem_dmem_port_arbiter
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_imem_dmem_port_arbiter                               |
// | Purpose  : Scoreboard bench. Stimulus pushes the expected read     |
// |            data and completion cycle per requester; a monitor pops |
// |            and compares on every ready pulse. Instance A uses      |
// |            LAT=2, instance B uses LAT=1 for back-to-back fetches.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_imem_dmem_port_arbiter;
  import arb_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A (LAT = 2)
  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_we;
  // Instance B (LAT = 1)
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we;

  exp_t q_aif[$];
  exp_t q_adm[$];
  exp_t q_bif[$];
  logic [31:0] st40;

  // Memory contents: a few instructions, one data word, and a
  // recognisable address-derived pattern everywhere else.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr)
      32'h10:  return 32'h0050_0093;
      32'h14:  return 32'h00A0_0113;
      32'h18:  return 32'h00F0_0193;
      32'h20:  return 32'h1111_1111;
      default: return {16'hA5A5, addr[15:0]};
    endcase
  endfunction

  always @(posedge clk)
    if (a_mem_en && a_mem_we && a_mem_addr == 32'h40) st40 <= a_mem_wdata;

  assign a_mem_rdata = !a_mem_en ? 32'h0 : (a_mem_addr == 32'h40) ? st40 : rom(a_mem_addr);
  assign b_mem_rdata = !b_mem_en ? 32'h0 : rom(b_mem_addr);

  imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2), .MAX_DM_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .MAX_DM_BURST(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] rdata, input exp_t e);
    n_tests++;
    if (rdata !== e.data || cyc != e.cyc) begin
      n_fail++;
      $display("FAIL %s: got data %h at cycle %0d expected data %h at cycle %0d",
               name, rdata, cyc, e.data, e.cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected ready pulse at cycle %0d", name, cyc);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if ((a_if_ready && a_dm_ready) || (b_if_ready && b_dm_ready)) begin
        n_fail++;
        $display("FAIL ready_excl: both ready pulses high at cycle %0d", cyc);
      end
      if (a_if_ready) begin
        if (q_aif.size() == 0) unexpected("a_if");
        else sb_check("a_if", a_if_rdata, q_aif.pop_front());
      end
      if (a_dm_ready) begin
        if (q_adm.size() == 0) unexpected("a_dm");
        else sb_check("a_dm", a_dm_rdata, q_adm.pop_front());
      end
      if (b_if_ready) begin
        if (q_bif.size() == 0) unexpected("b_if");
        else sb_check("b_if", b_if_rdata, q_bif.pop_front());
      end
      if (b_dm_ready) unexpected("b_dm");
    end
  endtask

  // Returns on the negedge where the chosen ready is high
  task automatic wait_pulse(input int which);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = a_if_ready;
        1:       seen = a_dm_ready;
        default: seen = b_if_ready;
      endcase
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no ready on port %0d by cycle %0d", which, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int exp_streak[6];
    exp_streak = '{1, 2, 3, 4, 0, 0};
    rst = 1'b1;
    a_if_req = 0; a_dm_req = 0; a_dm_we = 0; a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_dm_req = 0; b_dm_we = 0; b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_en",   32'(a_mem_en), 32'h0);
    chk("rst_mem_we",   32'(a_mem_we), 32'h0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_if_rdata", a_if_rdata, 32'h0);
    chk("rst_dm_rdata", a_dm_rdata, 32'h0);
    chk("rst_ready",    32'({a_if_ready, a_dm_ready}), 32'h0);

    // Single fetch: mem_en on cycles k+1..k+2, ready at k+3
    sync(); k = cyc;
    q_aif.push_back('{32'h0050_0093, k + 3});
    a_if_req = 1; a_if_addr = 32'h10;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("fetch_mem_en", 32'(a_mem_en), (c == 1 || c == 2) ? 32'h1 : 32'h0);
      if (c == 1 || c == 2) chk("fetch_mem_addr", a_mem_addr, 32'h10);
    end
    a_if_req = 0;

    // Simultaneous load + fetch: DM first (k+3), IF next (k+7)
    sync(); k = cyc;
    q_adm.push_back('{32'h1111_1111, k + 3});
    q_aif.push_back('{32'h00A0_0113, k + 7});
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h20;
    a_if_req = 1; a_if_addr = 32'h14;
    fork
      begin wait_pulse(1); a_dm_req = 0; end
      begin wait_pulse(0); a_if_req = 0; end
    join

    // Store: write strobe held two cycles, dm_rdata keeps the last load
    sync(); k = cyc;
    q_adm.push_back('{32'h1111_1111, k + 3});
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h40; a_dm_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("store_mem_we", 32'(a_mem_we), (c == 1 || c == 2) ? 32'h1 : 32'h0);
      if (c == 1 || c == 2) begin
        chk("store_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        chk("store_addr",  a_mem_addr,  32'h40);
      end
    end
    a_dm_req = 0; a_dm_we = 0;

    // Read back the stored word
    sync(); k = cyc;
    q_adm.push_back('{32'hDEAD_BEEF, k + 3});
    a_dm_req = 1; a_dm_addr = 32'h40;
    wait_pulse(1); a_dm_req = 0;

    // DM burst with IF pending: 4 DM, then IF, then 2 more DM
    sync(); k = cyc;
    for (int n = 0; n < 6; n++)
      q_adm.push_back('{32'hA5A5_0024 + 32'(4 * n), k + 3 + 4 * n + ((n >= 4) ? 4 : 0)});
    q_aif.push_back('{32'h00F0_0193, k + 19});
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h24;
    a_if_req = 1; a_if_addr = 32'h18;
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          wait_pulse(1);
          chk("burst_streak", 32'(dut_a.r_dm_streak), 32'(exp_streak[n]));
          a_dm_addr = 32'h28 + 32'(4 * n);
        end
        a_dm_req = 0;
      end
      begin wait_pulse(0); a_if_req = 0; end
    join

    // Reset during the first ACCESS cycle of a store
    sync(); k = cyc;
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h44; a_dm_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_mem_we", 32'(a_mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_en", 32'(a_mem_en), 32'h0);
    chk("async_rst_mem_we", 32'(a_mem_we), 32'h0);
    a_dm_req = 0; a_dm_we = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_mem_en", 32'(a_mem_en), 32'h0);
    chk("post_rst_state",  32'(dut_a.r_state), 32'(IDLE));
    chk("post_rst_dm_rdata", a_dm_rdata, 32'h0);

    // LAT = 1: back-to-back fetches complete every 3 cycles
    sync(); k = cyc;
    q_bif.push_back('{32'h0050_0093, k + 2});
    q_bif.push_back('{32'h00A0_0113, k + 5});
    q_bif.push_back('{32'h00F0_0193, k + 8});
    b_if_req = 1; b_if_addr = 32'h10;
    for (int n = 0; n < 3; n++) begin
      wait_pulse(2);
      b_if_addr = 32'h14 + 32'(4 * n);
    end
    b_if_req = 0;

    repeat (4) @(negedge clk);
    chk("leftover_a_if", 32'(q_aif.size()), 32'h0);
    chk("leftover_a_dm", 32'(q_adm.size()), 32'h0);
    chk("leftover_b_if", 32'(q_bif.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_dmem_port_arbiter
`default_nettype wire
